// File: rtl/truth_table_sweeper_pkg.sv
// ============================================================================
// tt_pkg : shared state encoding and vector-order mapping for the sweeper.
// Rev 1.0
// ============================================================================
`default_nettype none

// Sweep order: identity for binary, reflected Gray when g is true.
`define TT_ORDER(i, g) ((g) ? ((i) ^ ((i) >> 1)) : (i))

package tt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_vec_gen.sv
// ============================================================================
// tt_vec_gen : step index, hold counter and binary/Gray vector generation.
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_vec_gen
    import tt_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int HOLD = 2,
    parameter int GRAY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_adv,
    output logic [N_IN-1:0] o_vec,
    output logic            o_sample_stb,
    output logic            o_last_step
);

    localparam int              c_CW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(HOLD - 1);
    localparam logic [N_IN-1:0] c_LAST    = '1;

    logic [N_IN-1:0] r_idx;
    logic [c_CW-1:0] r_cnt;
    logic [N_IN-1:0] r_vec;
    logic [N_IN-1:0] w_idx_nxt;
    logic [N_IN-1:0] w_vec_nxt;

    assign w_idx_nxt    = r_idx + 1'b1;
    assign w_vec_nxt    = `TT_ORDER(w_idx_nxt, (GRAY != 0));
    assign o_sample_stb = (r_cnt == c_CNT_MAX);
    assign o_last_step  = (r_idx == c_LAST);
    assign o_vec        = r_vec;

    // On the last sample nothing moves, so vec keeps the final vector in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_load) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_adv) begin
            if (!o_sample_stb) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!o_last_step) begin
                r_idx <= w_idx_nxt;
                r_vec <= w_vec_nxt;
                r_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : exhaustive stimulus/capture/compare engine for an
// N_IN-input combinational DUT.  Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int HOLD = 2,
    parameter int GRAY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec,
    output logic                 vec_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [2**N_IN-1:0]   cap_tt,
    output logic [N_IN-1:0]      first_err_vec,
    output logic                 first_err_valid
);

    localparam int c_TT_W = 2**N_IN;
    localparam int c_EW   = N_IN + 1;

    state_t            r_state;
    logic [c_TT_W-1:0] r_exp;
    logic [c_TT_W-1:0] r_cap_tt;
    logic [c_EW-1:0]   r_err_cnt;
    logic [N_IN-1:0]   r_first_err_vec;
    logic              r_first_err_valid;
    logic              r_vec_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_load;
    logic              w_adv;
    logic [N_IN-1:0]   w_vec;
    logic              w_sample_stb;
    logic              w_last_step;
    logic              w_mismatch;
    logic [c_EW-1:0]   w_err_nxt;

    assign w_load     = (r_state != ST_RUN) && start && !abort;
    assign w_adv      = (r_state == ST_RUN) && !abort;
    assign w_mismatch = (dut_out != r_exp[w_vec]);
    assign w_err_nxt  = r_err_cnt + c_EW'(w_mismatch);

    tt_vec_gen #(
        .N_IN (N_IN),
        .HOLD (HOLD),
        .GRAY (GRAY)
    ) u_vec_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_adv        (w_adv),
        .o_vec        (w_vec),
        .o_sample_stb (w_sample_stb),
        .o_last_step  (w_last_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_exp             <= '0;
            r_cap_tt          <= '0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
            r_vec_valid       <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Abort wins over a coincident sample; partial results stay.
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_vec_valid <= 1'b0;
                        r_done      <= 1'b0;
                    end else if (w_sample_stb) begin
                        r_cap_tt[w_vec] <= dut_out;
                        if (w_mismatch) begin
                            r_err_cnt <= w_err_nxt;
                            if (!r_first_err_valid) begin
                                r_first_err_vec   <= w_vec;
                                r_first_err_valid <= 1'b1;
                            end
                        end
                        if (w_last_step) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_vec_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_pass      <= (w_err_nxt == '0);
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end else if (start) begin
                        r_state           <= ST_RUN;
                        r_exp             <= exp_tt;
                        r_cap_tt          <= '0;
                        r_err_cnt         <= '0;
                        r_first_err_vec   <= '0;
                        r_first_err_valid <= 1'b0;
                        r_vec_valid       <= 1'b1;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign vec             = w_vec;
    assign vec_valid       = r_vec_valid;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign cap_tt          = r_cap_tt;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : directed bench for truth_table_sweeper with a
// sweep-level reference model.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_truth_table_sweeper;

    localparam int N     = 4;
    localparam int H     = 2;
    localparam int TT    = 16;
    localparam int TOTAL = TT * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] exp_tt = 16'h0;
    logic        dout0, dout1;

    logic [3:0]  vec0, vec1, fev0, fev1;
    logic        vv0, vv1, busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
    logic [4:0]  err0, err1;
    logic [15:0] cap0, cap1;

    int n_checks = 0;
    int n_errs   = 0;
    logic cmp_en = 1'b0;
    logic [3:0] gl [16];

    always #5 clk = ~clk;

    function automatic logic f_dut(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    assign dout0 = f_dut(vec0);
    assign dout1 = f_dut(vec1);

    truth_table_sweeper #(.N_IN(N), .HOLD(H), .GRAY(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .dut_out(dout0), .vec(vec0), .vec_valid(vv0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0), .cap_tt(cap0), .first_err_vec(fev0),
        .first_err_valid(fv0));

    truth_table_sweeper #(.N_IN(N), .HOLD(H), .GRAY(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .dut_out(dout1), .vec(vec1), .vec_valid(vv1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .cap_tt(cap1), .first_err_vec(fev1),
        .first_err_valid(fv1));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Result of a binary sweep after n completed samples against table ex.
    function automatic void summ(input int n, input logic [15:0] ex, output logic [15:0] cap,
                                 output int err, output logic fv, output logic [3:0] fvec);
        logic [3:0] v;
        cap = '0; err = 0; fv = 1'b0; fvec = '0;
        for (int j = 0; j < n; j++) begin
            v = 4'(j);
            cap[v] = f_dut(v);
            if (f_dut(v) != ex[v]) begin
                err++;
                if (!fv) begin
                    fv = 1'b1;
                    fvec = v;
                end
            end
        end
    endfunction

    // Model of the binary instance: 0 idle, 1 running, 2 done.
    int          m_st = 0, m_t = 0, m_n = 0, m_vi = 0;
    logic [15:0] m_exp = '0;
    logic        m_pass = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [15:0] c; int e; logic f; logic [3:0] fv;
        if (rst) begin
            m_st = 0; m_t = 0; m_n = 0; m_vi = 0; m_exp = '0; m_pass = 1'b0;
        end else if (m_st == 1) begin
            if (abort) m_st = 0;
            else begin
                m_t++;
                m_n = m_t / H;
                if (m_t == TOTAL) begin
                    m_st = 2;
                    m_vi = TT - 1;
                    summ(m_n, m_exp, c, e, f, fv);
                    m_pass = (e == 0);
                end else begin
                    m_vi = m_t / H;
                end
            end
        end else if (abort) begin
            m_st = 0;
        end else if (start) begin
            m_st = 1; m_t = 0; m_n = 0; m_vi = 0; m_exp = exp_tt; m_pass = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e_cap; int e_err; logic e_fv; logic [3:0] e_fvec;
        if (!rst && cmp_en) begin
            summ(m_n, m_exp, e_cap, e_err, e_fv, e_fvec);
            chk("m_vec",       32'(vec0),  32'(m_vi));
            chk("m_busy",      32'(busy0), 32'(m_st == 1));
            chk("m_vec_valid", 32'(vv0),   32'(m_st == 1));
            chk("m_done",      32'(done0), 32'(m_st == 2));
            chk("m_pass",      32'(pass0), 32'(m_pass));
            chk("m_err_cnt",   32'(err0),  32'(e_err));
            chk("m_cap_tt",    32'(cap0),  32'(e_cap));
            chk("m_first_vld", 32'(fv0),   32'(e_fv));
            chk("m_first_vec", 32'(fev0),  32'(e_fvec));
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Counts busy cycles until the sweep ends; optionally checks Gray order.
    task automatic run_count(input bit gchk, output int cyc);
        cyc = 0;
        while (busy0 && cyc < 100) begin
            if (gchk && (cyc % 2) == 0 && cyc < 32) chk("gray_vec", 32'(vec1), 32'(gl[cyc/2]));
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},   32'(vec0),  0);
        chk({tag, "_busy"},  32'(busy0), 0);
        chk({tag, "_vv"},    32'(vv0),   0);
        chk({tag, "_done"},  32'(done0), 0);
        chk({tag, "_pass"},  32'(pass0), 0);
        chk({tag, "_err"},   32'(err0),  0);
        chk({tag, "_cap"},   32'(cap0),  0);
        chk({tag, "_fv"},    32'(fv0),   0);
        chk({tag, "_fev"},   32'(fev0),  0);
        chk({tag, "_vec_g"}, 32'(vec1),  0);
    endtask

    initial begin
        int cyc;
        gl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
               4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        #3 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Clean run on both instances.
        exp_tt = 16'hF888;
        do_start();
        run_count(1'b1, cyc);
        chk("clean_len", 32'(cyc), 32);
        chk("clean_done", 32'(done0), 1);
        chk("clean_pass", 32'(pass0), 1);
        chk("clean_err", 32'(err0), 0);
        chk("clean_cap", 32'(cap0), 32'h F888);
        chk("clean_fv", 32'(fv0), 0);
        chk("gray_done", 32'(done1), 1);
        chk("gray_pass", 32'(pass1), 1);
        chk("gray_cap", 32'(cap1), 32'h F888);
        chk("gray_last_vec", 32'(vec1), 8);

        // Bit 0 wrong, and exp_tt changed after start.
        exp_tt = 16'hF889;
        do_start();
        exp_tt = 16'h0000;
        run_count(1'b0, cyc);
        chk("mm_len", 32'(cyc), 32);
        chk("mm_err", 32'(err0), 1);
        chk("mm_fev", 32'(fev0), 0);
        chk("mm_fv", 32'(fv0), 1);
        chk("mm_pass", 32'(pass0), 0);
        chk("mm_cap", 32'(cap0), 32'h F888);

        // start held in DONE restarts with cleared results, now against 0x0000.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_err", 32'(err0), 0);
        chk("restart_cap", 32'(cap0), 0);
        chk("restart_busy", 32'(busy0), 1);
        chk("restart_done", 32'(done0), 0);
        run_count(1'b0, cyc);
        chk("zero_len", 32'(cyc), 32);
        chk("zero_err", 32'(err0), 7);
        chk("zero_fev", 32'(fev0), 3);
        chk("zero_pass", 32'(pass0), 0);

        // abort in DONE.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_done", 32'(done0), 0);

        // Abort mid-run, then restart.
        exp_tt = 16'hF888;
        do_start();
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_done", 32'(done0), 0);
        chk("abort_vv", 32'(vv0), 0);
        do_start();
        run_count(1'b0, cyc);
        chk("after_abort_len", 32'(cyc), 32);
        chk("after_abort_pass", 32'(pass0), 1);

        // start and abort together in DONE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("both_busy", 32'(busy0), 0);
        chk("both_done", 32'(done0), 0);

        // start pulses during RUN are ignored.
        do_start();
        repeat (3) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        run_count(1'b0, cyc);
        chk("pulse_len", 32'(cyc + 9), 32);
        chk("pulse_pass", 32'(pass0), 1);

        // Asynchronous reset in the middle of a run.
        do_start();
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy0), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised hardware stimulus/response engine for an N-input, 1-output combinational DUT.
- On start, walks all 2^N_IN input vectors in binary or Gray order.
- Holds each vector for HOLD cycles, then samples the DUT output into a captured truth table.
- Compares each sample against an expected truth table; reports pass, error count and first failing vector.
- Sits beside the combinational lab modules as the on-chip, self-checking, clocked replacement for hand-written exhaustive stimulus lists.

Parameters:
- N_IN, 4: number of DUT inputs. Range 1..8.
- HOLD, 2: cycles each vector is held before sampling. Must be >= 1.
- GRAY, 0: vector order. 0 = binary count; 1 = reflected Gray, where vec = i ^ (i >> 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep. Sampled only in IDLE or DONE.
- abort  in  1  cancel the sweep in progress.
- exp_tt  in  2^N_IN  expected truth table. Bit k is the expected output for vec == k.
- dut_out  in  1  DUT response.
- vec  out  N_IN  vector driven to the DUT. MSB is the first DUT input.
- vec_valid  out  1  high while vec is being driven (state RUN).
- busy  out  1  high in RUN.
- done  out  1  high in DONE. Held until the next start or abort.
- pass  out  1  valid when done. 1 iff err_cnt == 0.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- cap_tt  out  2^N_IN  captured truth table. Bit k is the sampled dut_out for vec == k.
- first_err_vec  out  N_IN  vec value of the first mismatch.
- first_err_valid  out  1  at least one mismatch recorded this sweep.

Behaviour:
- Reset (async, immediate): state = IDLE. vec, vec_valid, busy, done, pass, err_cnt, cap_tt, first_err_vec and first_err_valid all = 0. Step index and hold counter = 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on the edge where start = 1. On that edge:
  - latch exp_tt into an internal copy (mid-sweep changes to exp_tt are ignored);
  - clear err_cnt, cap_tt, first_err_vec, first_err_valid, done and pass;
  - set step index i = 0, hold counter = 0, vec = order(0) = 0.
- RUN, per edge:
  - If hold counter < HOLD-1: increment the counter. vec is unchanged.
  - If hold counter == HOLD-1 (sample edge):
    - cap_tt[vec] <= dut_out;
    - on mismatch with latched_exp[vec]: err_cnt += 1; if first_err_valid = 0, set first_err_vec = vec and first_err_valid = 1;
    - if i < 2^N_IN-1: i += 1, vec = order(i), counter = 0;
    - else -> DONE.
- Timing: the final sample occurs on edge 2^N_IN*HOLD after the start edge. done and pass are visible after that edge. The DUT sees each vector for exactly HOLD full cycles.
- DONE: vec holds the last vector. vec_valid = 0, busy = 0, done = 1, pass = (err_cnt == 0). All results stay stable.
- abort = 1 in RUN -> IDLE on that edge. busy, vec_valid and done go to 0. Partial results are kept but are not valid (done = 0). abort has priority over a sample on the same edge: that sample is discarded.
- abort in IDLE/DONE: DONE -> IDLE with done = 0. Otherwise no effect.
- start while in RUN is ignored.
- start and abort both high in IDLE/DONE: abort wins, state = IDLE.
- Arithmetic: err_cnt saturation is never needed, since its maximum value is 2^N_IN.
- Hold counter width: max(1, $clog2(HOLD)). HOLD = 1 samples on every edge.
- cap_tt is indexed by vec value, not by step index, so cap_tt is identical for GRAY = 0 and GRAY = 1.

Decomposition:
- Shared package (tt_pkg): state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, and an order-function macro/constant for Gray conversion.
- One natural sub-module: tt_vec_gen. Holds the step index, the hold counter and binary/Gray mapping. Outputs vec, sample_stb and last_step.
- The top level holds the FSM, capture and compare logic.

Test Plan:
- Test DUT model: f = (a&b)|(c&d), with vec = {a,b,c,d}. Settings N_IN = 4, HOLD = 2, expected table 0xF888.
- Reset: assert rst mid-cycle -> all outputs 0 immediately, asynchronously, before the next clk edge.
- Clean run: start with exp_tt = 0xF888 and the DUT model -> busy for 32 cycles, vec steps 0..15 every 2 cycles. Then done = 1, pass = 1, err_cnt = 0, cap_tt = 0xF888, first_err_valid = 0.
- Mismatch: exp_tt = 0xF889 (bit 0 wrong), plus exp_tt changed to 0x0000 after start -> latched copy used. Result: err_cnt = 1, first_err_vec = 0, first_err_valid = 1, pass = 0, cap_tt = 0xF888.
- Gray order: GRAY = 1 -> vec sequence 0,1,3,2,6,7,5,4,12,... Final cap_tt = 0xF888, pass = 1, done after 32 cycles.
- Abort and restart: abort 10 cycles after start -> IDLE, busy = 0, done = 0. A new start gives a full 32-cycle run with pass = 1. rst asserted mid-RUN -> IDLE with all outputs 0.
- Start handling: start pulses during RUN -> ignored, and done still arrives at cycle 32. start held in DONE -> new sweep begins with err_cnt and cap_tt cleared on that edge.
